// File: rtl/mem_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_master_pkg : shared state encoding and defaults for mem_master  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_wait_counter : loadable down-counter, saturates at zero         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign is_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_master : request/done sequencer for the word-addressed memory   |
// | Optional: MEM_MASTER_ALIGN_CHECK_EN rejects misaligned requests.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_master
  import mem_master_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             fault,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_write_data,
  output logic             mem_write_enable,
  input  logic [WIDTH-1:0] mem_read_data
);

  localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYCLES);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             w_accept;
  logic             w_misalign;
  logic             w_dec;
  logic             w_capture;
  logic             w_cnt_zero;

  mem_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_accept),
    .value   (c_wait_load),
    .dec     (w_dec),
    .is_zero (w_cnt_zero)
  );

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  assign w_misalign = (req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_dec        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept     = 1'b1;
          w_next_state = w_misalign ? DONE : WAIT;
        end
      end
      WAIT: begin
        // counter==0 marks the access cycle: strobe/capture happen here
        if (w_cnt_zero) begin
          w_capture    = ~r_we;
          w_next_state = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_capture) begin
        r_rdata <= mem_read_data;
      end
    end
  end

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_misalign;
    end
  end

  assign fault = r_fault && (r_state == DONE);
`else
  assign fault = 1'b0;
`endif

  assign busy             = (r_state == WAIT);
  assign done             = (r_state == DONE);
  assign rdata            = r_rdata;
  assign mem_a            = r_addr;
  assign mem_write_data   = r_wdata;
  assign mem_write_enable = (r_state == WAIT) && w_cnt_zero && r_we;

endmodule
`default_nettype wire

// File: doc/mem_master.md
# mem_master

Initiator-side sequencer for the word-addressed data/instruction memory in the multicycle CPU. Accepts a single read or write request from the control unit, drives the memory port for a programmable number of wait cycles, commits the write or captures the read word, then pulses completion. It sits between the control FSM and the memory, giving the controller a latency-tolerant request/done handshake instead of a same-cycle combinational access.

## Interface
- WIDTH, 32: address and data width.
- WAIT_CYCLES, 1: extra cycles the address is held before the access cycle; legal range 0..15.
- CNT_W, 4: wait counter width; must hold WAIT_CYCLES.

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request level from control unit; sampled only in IDLE.
- req_we  in  1  1 = write, 0 = read; sampled with req.
- req_addr  in  WIDTH  byte address; sampled with req.
- req_wdata  in  WIDTH  write data; sampled with req.
- busy  out  1  high while in WAIT.
- done  out  1  single-cycle completion pulse.
- rdata  out  WIDTH  last captured read word; held until the next read completes.
- fault  out  1  misaligned-access flag, valid with done.
- mem_a  out  WIDTH  memory address (latched request address).
- mem_write_data  out  WIDTH  memory write data (latched).
- mem_write_enable  out  1  memory write strobe.
- mem_read_data  in  WIDTH  combinational memory read data.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: busy=0, done=0. If req=1 at a rising edge: latch req_we/req_addr/req_wdata, load counter with WAIT_CYCLES, go to WAIT.
- WAIT: busy=1; mem_a/mem_write_data driven from latched registers throughout; counter decrements each cycle while nonzero.
- Access cycle = WAIT cycle with counter==0. mem_write_enable = (state==WAIT && counter==0 && we_q), combinational from registered state; low in every other cycle. For reads, rdata <= mem_read_data at the edge ending the access cycle. Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle; req ignored; go to IDLE unconditionally.
- req held high through DONE is accepted again in the following IDLE cycle (back-to-back rate: one access per WAIT_CYCLES+3 cycles).
- Writes never modify rdata. Read and write share one path; no outstanding-request queue.
- Reset (asynchronous, any state, including mid-WAIT): state=IDLE, counter=0, latched address/data/we=0, rdata=0; outputs busy=0, done=0, fault=0, mem_write_enable=0, mem_a=0, mem_write_data=0. An interrupted write is never committed.

## Timing
- req sampled at edge k → WAIT for WAIT_CYCLES+1 cycles → done high in cycle after edge k+WAIT_CYCLES+1.
- WAIT_CYCLES=0: single WAIT cycle which is the access cycle; done two cycles after req sampled.
- rdata valid in the done cycle and stable afterwards.
- mem_write_enable high for exactly one cycle per write.

## Configuration
- MEM_MASTER_ALIGN_CHECK_EN defined: at acceptance, req_addr[1:0]≠0 skips WAIT, goes directly to DONE with done=1, fault=1; no memory write, rdata unchanged. fault=0 on every aligned completion.
- Not defined: address low bits passed through unchanged (memory ignores them); fault tied to 0; no extra state logic.

## Structure
- Package mem_master_pkg: state enum typedef (IDLE, WAIT, DONE; 2-bit), DEFAULT_WAIT_CYCLES constant.
- One sub-module: mem_wait_counter — loadable down-counter (load, value, is_zero), asynchronous active-low reset.

## Test plan
- Read, WAIT_CYCLES=1: memory word 3 = 0xDEADBEEF, req=1, req_we=0, req_addr=0x0C → busy high 2 cycles, done 3 cycles after req sampled, rdata=0xDEADBEEF, mem_write_enable never high.
- Write then read: write 0x12345678 to 0x20 → mem_write_enable high exactly one cycle with mem_a=0x20; subsequent read of 0x20 returns 0x12345678; rdata unchanged by the write.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: done at req+2 and req+17 cycles respectively.
- req held high continuously, four reads → done pulses spaced WAIT_CYCLES+3 cycles apart, no request lost or duplicated.
- Reset asserted mid-WAIT of a write to 0x40 → immediate IDLE, all outputs 0, memory at 0x40 unchanged.
- With MEM_MASTER_ALIGN_CHECK_EN, req_addr=0x06 → done and fault high in cycle after acceptance, no write strobe, rdata unchanged; aligned access afterwards completes with fault=0.
